uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX path. It detects the start edge, counts oversampling edges and bits, and drives single-cycle enables to the sampler, deserializer and the start, parity and stop checkers. It collects their error results and issues a one-cycle data_valid per good frame. It sits between RX_IN and the RX datapath blocks, under the RX top.

---
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, oversampling edge/bit counting and checker strobes.
// Optional UART_RX_ERR_FLAGS_EN adds par_err_flag / stp_err_flag rejection pulses.
module uart_rx_ctrl #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  par_err,
    input  logic                  strt_glitch,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
    output logic                  par_err_flag,
    output logic                  stp_err_flag,
`endif
    output logic                  data_valid
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_nxt;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic [PRESCALE_W-1:0]   edge_q;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    par_en_q;
    logic                    err_flag;
    logic                    frame_start;
    logic                    last_edge;
    logic                    chk_edge;
    logic                    vld_nxt;
    logic                    vld_p1;

    // Checkers see a majority vote around edge H, so the result is ready at H+2.
    assign last_edge = (edge_q == prescale_q - ONE);
    assign chk_edge  = (edge_q == (prescale_q >> 1) + TWO);

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        vld_nxt     = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt   = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                strt_chk_en = chk_edge;
                if (last_edge) state_nxt = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_en = chk_edge;
                if (last_edge && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = chk_edge;
                if (last_edge) state_nxt = STOP;
            end
            STOP: begin
                stp_chk_en = chk_edge;
                if (last_edge) begin
                    vld_nxt = !stp_err && !err_flag;
                    if (!RX_IN) begin
                        state_nxt   = START;
                        frame_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            edge_q     <= '0;
            bit_cnt    <= '0;
            err_flag   <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= vld_nxt;
            if (frame_start) begin
                // Frame configuration is frozen here; later input changes are ignored.
                prescale_q <= Prescale;
                par_en_q   <= PAR_EN;
                edge_q     <= '0;
                bit_cnt    <= '0;
                err_flag   <= 1'b0;
            end else if (state != IDLE) begin
                edge_q <= last_edge ? '0 : edge_q + ONE;
                if (state == DATA && last_edge) bit_cnt <= bit_cnt + BIT_W'(1);
                if (state == PARITY && last_edge) err_flag <= par_err;
            end
        end
    end

`ifdef UART_RX_ERR_FLAGS_EN
    logic par_flag_p1, stp_flag_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_flag_p1 <= 1'b0;
            stp_flag_p1 <= 1'b0;
        end else begin
            par_flag_p1 <= (state == STOP) && last_edge && err_flag;
            stp_flag_p1 <= (state == STOP) && last_edge && stp_err;
        end
    end

    assign par_err_flag = par_flag_p1;
    assign stp_err_flag = stp_flag_p1;
`endif

    assign dat_samp_en = (state != IDLE);
    assign edge_cnt    = edge_q;
    assign data_valid  = vld_p1;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table-driven frames plus glitch, back-to-back and mid-frame reset.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       par_err, strt_glitch, stp_err;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
    logic [5:0] edge_cnt;
`ifdef UART_RX_ERR_FLAGS_EN
    logic       par_err_flag, stp_err_flag;
`endif

    uart_rx_ctrl #(.PRESCALE_W(6), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .par_err(par_err), .strt_glitch(strt_glitch), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
`ifdef UART_RX_ERR_FLAGS_EN
        .par_err_flag(par_err_flag), .stp_err_flag(stp_err_flag),
`endif
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Monitor: all counters are written only here and read as deltas by the stimulus.
    int cyc = 0, n_samp = 0, n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0, n_dv = 0;
    int n_bad_edge = 0, n_multi = 0, rise_cyc = 0, last_dv = 0, prev_dv = 0;
    int n_pflag = 0, n_sflag = 0;
    int exp_chk = 6;
    logic samp_d = 1'b0;

    always @(negedge clk) begin
        int ns;
        ns = int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en);
        cyc <= cyc + 1;
        samp_d <= dat_samp_en;
        if (dat_samp_en && !samp_d) rise_cyc <= cyc;
        if (dat_samp_en) n_samp <= n_samp + 1;
        if (strt_chk_en) n_strt <= n_strt + 1;
        if (deser_en) n_deser <= n_deser + 1;
        if (par_chk_en) n_par <= n_par + 1;
        if (stp_chk_en) n_stp <= n_stp + 1;
        if (ns > 1 || (ns != 0 && !dat_samp_en)) n_multi <= n_multi + 1;
        if (ns != 0 && int'(edge_cnt) != exp_chk) n_bad_edge <= n_bad_edge + 1;
        if (data_valid) begin
            n_dv    <= n_dv + 1;
            prev_dv <= last_dv;
            last_dv <= cyc;
        end
`ifdef UART_RX_ERR_FLAGS_EN
        if (par_err_flag) n_pflag <= n_pflag + 1;
        if (stp_err_flag) n_sflag <= n_sflag + 1;
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int         p;
        bit         par_en;
        logic [7:0] data;
        bit         stop_bit;
        bit         perr;
        bit         serr;
        int         e_par;
        int         e_dv;
        int         e_len;
    } vec_t;

    vec_t vecs[5];

    // Drives start, data LSB-first, optional even parity, stop; decoy config after the start bit.
    task automatic drive_frame(input int p, input bit par_en, input logic [7:0] d, input bit stop_bit);
        RX_IN = 1'b0;
        tick(p);
        Prescale = (p == 8) ? 6'd32 : 6'd8;
        PAR_EN   = ~par_en;
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            tick(p);
        end
        if (par_en) begin
            RX_IN = ^d;
            tick(p);
        end
        RX_IN = stop_bit;
        tick(p);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int s_samp, s_strt, s_deser, s_par, s_stp, s_dv, s_bad, s_multi, s_pf, s_sf;
        string tag;
        tag = $sformatf("v%0d", idx);
        Prescale = 6'(v.p); PAR_EN = v.par_en;
        par_err = v.perr; stp_err = v.serr; strt_glitch = 1'b0;
        exp_chk = v.p / 2 + 2;
        tick(1);
        s_samp = n_samp; s_strt = n_strt; s_deser = n_deser; s_par = n_par; s_stp = n_stp;
        s_dv = n_dv; s_bad = n_bad_edge; s_multi = n_multi; s_pf = n_pflag; s_sf = n_sflag;
        drive_frame(v.p, v.par_en, v.data, v.stop_bit);
        RX_IN = 1'b1;
        tick(2 * v.p + 4);
        chk({tag, "_strt"},  n_strt - s_strt, 1);
        chk({tag, "_deser"}, n_deser - s_deser, 8);
        chk({tag, "_par"},   n_par - s_par, v.e_par);
        chk({tag, "_stp"},   n_stp - s_stp, 1);
        chk({tag, "_dv"},    n_dv - s_dv, v.e_dv);
        chk({tag, "_len"},   n_samp - s_samp, v.e_len);
        chk({tag, "_edge"},  n_bad_edge - s_bad, 0);
        chk({tag, "_excl"},  n_multi - s_multi, 0);
        if (v.e_dv == 1) chk({tag, "_lat"}, last_dv - rise_cyc, v.e_len);
`ifdef UART_RX_ERR_FLAGS_EN
        chk({tag, "_pflag"}, n_pflag - s_pf, int'(v.perr && v.par_en));
        chk({tag, "_sflag"}, n_sflag - s_sf, int'(v.serr));
`endif
    endtask

    initial begin
        int s_samp, s_strt, s_deser, s_dv, s_multi;
        vecs[0] = '{8,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1, 1, 88};
        vecs[1] = '{16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1, 0, 176};
        vecs[2] = '{32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 0, 0, 320};
        vecs[3] = '{16, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1, 160};
        vecs[4] = '{8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1, 80};

        rst_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
        #12;
        chk("rst_outs", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
        chk("rst_edge", int'(edge_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(5);
        chk("idle_samp", int'(dat_samp_en), 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Start glitch: line low for two cycles, start checker reports high.
        Prescale = 6'd8; PAR_EN = 1'b0; strt_glitch = 1'b1; exp_chk = 6;
        s_samp = n_samp; s_strt = n_strt; s_deser = n_deser; s_dv = n_dv;
        RX_IN = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(20);
        chk("glitch_len", n_samp - s_samp, 8);
        chk("glitch_strt", n_strt - s_strt, 1);
        chk("glitch_deser", n_deser - s_deser, 0);
        chk("glitch_dv", n_dv - s_dv, 0);
        chk("glitch_idle", int'(dat_samp_en), 0);
        strt_glitch = 1'b0;

        // Back-to-back frames, no idle gap.
        s_samp = n_samp; s_dv = n_dv; s_multi = n_multi;
        drive_frame(8, 1'b0, 8'hC3, 1'b1);
        Prescale = 6'd8; PAR_EN = 1'b0;
        drive_frame(8, 1'b0, 8'h81, 1'b1);
        RX_IN = 1'b1;
        tick(20);
        chk("b2b_dv", n_dv - s_dv, 2);
        chk("b2b_gap", last_dv - prev_dv, 80);
        chk("b2b_len", n_samp - s_samp, 160);
        chk("b2b_excl", n_multi - s_multi, 0);

        // Reset in the middle of data bit 3.
        Prescale = 6'd8; PAR_EN = 1'b0;
        s_dv = n_dv;
        RX_IN = 1'b0;
        tick(8);
        RX_IN = 1'b1;
        tick(8 * 3 + 3);
        chk("mid_active", int'(dat_samp_en), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
        chk("mid_rst_edge", int'(edge_cnt), 0);
        tick(3);
        rst_n = 1'b1;
        tick(100);
        chk("mid_rst_dv", n_dv - s_dv, 0);
        run_vec(5, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
